// File: rtl/sub64_seq_pkg.sv
// Shared types for the sequential 64-bit subtractor (state encoding, data width, index sizing).
// Optional compare outputs are enabled by defining SUB64_CMP_EN.
package sub64_seq_pkg;

  localparam int DATA_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Chunk counter width; a single-chunk build still needs a 1-bit counter.
  function automatic int idx_width(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/sub64_seq_if.sv
// Operand/result handshake bundle for sub64_seq; master drives operands and out_ready.
// lt/ltu exist only when SUB64_CMP_EN is defined.
interface sub64_seq_if;
  import sub64_seq_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] diff;
  logic              borrow;
  logic              overflow;
  logic              zero;
`ifdef SUB64_CMP_EN
  logic              lt;
  logic              ltu;
`endif

  modport master (
    output in_valid, a, b, out_ready,
`ifdef SUB64_CMP_EN
    input  lt, ltu,
`endif
    input  in_ready, out_valid, diff, borrow, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, out_ready,
`ifdef SUB64_CMP_EN
    output lt, ltu,
`endif
    output in_ready, out_valid, diff, borrow, overflow, zero
  );

endinterface

// File: rtl/sub64_seq_sub_chunk.sv
// One W-bit slice of a - b: d_c = a_c + ~b_c + cin, with carry out (carry=1 means no borrow).
module sub64_seq_sub_chunk #(
  parameter int W = 16
) (
  input  logic [W-1:0] a_c,
  input  logic [W-1:0] b_c,
  input  logic         cin,
  output logic [W-1:0] d_c,
  output logic         cout
);

  logic [W:0] sum;

  assign sum         = {1'b0, a_c} + {1'b0, ~b_c} + {{W{1'b0}}, cin};
  assign {cout, d_c} = sum;

endmodule

// File: rtl/sub64_seq.sv
// Multi-cycle 64-bit subtractor, CHUNK_W bits per cycle, with borrow/overflow/zero flags.
// Result valid DATA_W/CHUNK_W cycles after accept; SUB64_CMP_EN adds lt/ltu outputs.
module sub64_seq
  import sub64_seq_pkg::*;
#(
  parameter int CHUNK_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  sub64_seq_if.slave bus
);

  localparam int                 NCHUNK   = DATA_W / CHUNK_W;
  localparam int                 IDX_W    = idx_width(NCHUNK);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NCHUNK - 1);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DATA_W-1:0]   diff_q, diff_d;
  logic                carry_q, carry_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                borrow_q, borrow_d;
  logic                overflow_q, overflow_d;
  logic                zero_q, zero_d;
`ifdef SUB64_CMP_EN
  logic                lt_q, lt_d;
  logic                ltu_q, ltu_d;
`endif

  logic [6:0]          lo;
  logic [CHUNK_W-1:0]  a_c, b_c, d_c;
  logic                cout;
  logic [DATA_W-1:0]   diff_ins;
  logic                last;

  // Chunks are picked by shifting so the bit offset never needs a narrow index.
  assign lo       = 7'(idx_q) * 7'(CHUNK_W);
  assign a_c      = CHUNK_W'(a_q >> lo);
  assign b_c      = CHUNK_W'(b_q >> lo);
  assign diff_ins = diff_q | (DATA_W'(d_c) << lo);
  assign last     = (idx_q == LAST_IDX);

  sub64_seq_sub_chunk #(.W(CHUNK_W)) u_chunk (
    .a_c  (a_c),
    .b_c  (b_c),
    .cin  (carry_q),
    .d_c  (d_c),
    .cout (cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      diff_q     <= '0;
      carry_q    <= 1'b0;
      idx_q      <= '0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
`ifdef SUB64_CMP_EN
      lt_q       <= 1'b0;
      ltu_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      diff_q     <= diff_d;
      carry_q    <= carry_d;
      idx_q      <= idx_d;
      borrow_q   <= borrow_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
`ifdef SUB64_CMP_EN
      lt_q       <= lt_d;
      ltu_q      <= ltu_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (bus.in_valid) state_d = ST_CALC;
      ST_CALC: if (last)         state_d = ST_DONE;
      ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
      default:                   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    a_d        = a_q;
    b_d        = b_q;
    diff_d     = diff_q;
    carry_d    = carry_q;
    idx_d      = idx_q;
    borrow_d   = borrow_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;
`ifdef SUB64_CMP_EN
    lt_d       = lt_q;
    ltu_d      = ltu_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          diff_d  = '0;
          carry_d = 1'b1;
          idx_d   = '0;
        end
      end
      ST_CALC: begin
        diff_d  = diff_ins;
        carry_d = cout;
        idx_d   = idx_q + IDX_W'(1);
        // Flags come from the fully assembled difference on the last chunk.
        if (last) begin
          borrow_d   = ~cout;
          overflow_d = (a_q[DATA_W-1] ^ b_q[DATA_W-1]) & (diff_ins[DATA_W-1] ^ a_q[DATA_W-1]);
          zero_d     = ~|diff_ins;
`ifdef SUB64_CMP_EN
          lt_d       = diff_ins[DATA_W-1] ^ ((a_q[DATA_W-1] ^ b_q[DATA_W-1]) &
                                             (diff_ins[DATA_W-1] ^ a_q[DATA_W-1]));
          ltu_d      = ~cout;
`endif
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          borrow_d   = 1'b0;
          overflow_d = 1'b0;
          zero_d     = 1'b0;
`ifdef SUB64_CMP_EN
          lt_d       = 1'b0;
          ltu_d      = 1'b0;
`endif
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == ST_IDLE);
    bus.out_valid = (state_q == ST_DONE);
    bus.diff      = diff_q;
    bus.borrow    = borrow_q;
    bus.overflow  = overflow_q;
    bus.zero      = zero_q;
`ifdef SUB64_CMP_EN
    bus.lt        = lt_q;
    bus.ltu       = ltu_q;
`endif
  end

endmodule
